ifetch_prefetch: RTL and testbench

Instruction prefetch unit sitting directly upstream of the pipeline's IF stage, between the core and the instruction memory bus. It issues word fetches on a request/ready bus with an in-order, variable-latency response channel and buffers returned instructions in a small FIFO. It presents `{pc, instr}` pairs to IF over a valid/ready handshake. A redirect (taken branch/jump from the MEM-stage ALU result) flushes the FIFO, discards in-flight responses, and restarts fetch at the new PC.

---
 rtl/ifetch_prefetch.sv | 240 ++++++++++++++++++++++++
 tb/tb_ifetch_prefetch.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch.sv
// ----------------------------------------------------------------------------
// ifetch_prefetch
//
// Instruction prefetch unit between the core's IF stage and the instruction
// memory bus. It issues word fetches on a request/ready bus and receives
// responses in order, with variable latency. Returned words go into a small
// FIFO as {pc, instr} pairs. IF drains that FIFO over a valid/ready handshake.
// A redirect flushes the FIFO, marks every in-flight response for discard,
// and restarts fetching at the new PC.
//
// Parameters
//   DEPTH     FIFO entries and maximum outstanding requests (power of two, >=2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk_i            clock, rising edge
//   reset_ni         asynchronous active-low reset
//   instr_valid_o    FIFO head valid
//   instr_o          instruction word at FIFO head
//   instr_pc_o       PC of instr_o
//   instr_ready_i    IF consumes the head this cycle
//   redirect_i       flush and restart fetch at redirect_pc_i
//   redirect_pc_i    new fetch PC (bits [1:0] ignored)
//   mem_req_valid_o  fetch request valid
//   mem_req_addr_o   word-aligned fetch address
//   mem_req_ready_i  memory accepts the request
//   mem_rsp_valid_i  response word valid (in request order)
//   mem_rsp_data_i   response word
// ----------------------------------------------------------------------------
module ifetch_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0001_0000
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_valid_o,
  output logic [31:0] mem_req_addr_o,
  input  logic        mem_req_ready_i,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rsp_data_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] discard_reg, discard_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] tag_rd_ptr_reg, tag_rd_ptr_next;
  logic [AW-1:0] tag_wr_ptr_reg, tag_wr_ptr_next;

  // Low for the first edge after reset release. This keeps the request line
  // quiet while reset is asserted, and the flag is itself registered state.
  logic          req_en_reg;

  // Per-entry storage. The entries are built in the generate loops below and
  // collected here for the read muxes.
  logic [DEPTH-1:0][31:0] fifo_pc_w;
  logic [DEPTH-1:0][31:0] fifo_instr_w;
  logic [DEPTH-1:0][31:0] tag_pc_w;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic [CW:0] credit_used;
  logic        req_fire;
  logic        rsp_take;
  logic        rsp_keep;
  logic        rsp_drop;
  logic        pop;
  logic [31:0] tag_head;

  // The two low address bits of a redirect target are don't-care.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // A request is issued only when a FIFO slot is reserved for its response.
  // That way an accepted response can always be written.
  assign credit_used     = {1'b0, count_reg} + {1'b0, outstanding_reg};
  assign mem_req_valid_o = req_en_reg & (credit_used < DEPTH_EXT);
  assign mem_req_addr_o  = fetch_pc_reg;

  assign req_fire = mem_req_valid_o & mem_req_ready_i;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_take = mem_rsp_valid_i & (outstanding_reg != '0);
  // A response that arrives in a redirect cycle belongs to the old stream.
  // It is consumed here and never written to the FIFO.
  assign rsp_keep = rsp_take & (discard_reg == '0) & ~redirect_i;
  assign rsp_drop = rsp_take & (discard_reg != '0);
  assign pop      = instr_valid_o & instr_ready_i;
  assign tag_head = tag_pc_w[tag_rd_ptr_reg];

  assign instr_valid_o = (count_reg != '0);
  assign instr_o       = fifo_instr_w[rd_ptr_reg];
  assign instr_pc_o    = fifo_pc_w[rd_ptr_reg];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (req_fire) begin
      fetch_pc_next = fetch_pc_reg + 32'd4;
    end
    if (redirect_i) begin
      fetch_pc_next = {redirect_pc_i[31:2], 2'b00};
    end

    outstanding_next = outstanding_reg;
    if (req_fire && !rsp_take) begin
      outstanding_next = outstanding_reg + CNT_ONE;
    end else if (!req_fire && rsp_take) begin
      outstanding_next = outstanding_reg - CNT_ONE;
    end

    // After a flush, every request still in flight must be dropped. This
    // count includes a request accepted in the redirect cycle, and excludes a
    // response consumed in that same cycle.
    discard_next = discard_reg;
    if (redirect_i) begin
      discard_next = outstanding_next;
    end else if (rsp_drop) begin
      discard_next = discard_reg - CNT_ONE;
    end

    count_next = count_reg;
    if (redirect_i) begin
      count_next = '0;
    end else if (rsp_keep && !pop) begin
      count_next = count_reg + CNT_ONE;
    end else if (pop && !rsp_keep) begin
      count_next = count_reg - CNT_ONE;
    end

    rd_ptr_next = rd_ptr_reg;
    if (redirect_i) begin
      rd_ptr_next = wr_ptr_reg;
    end else if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end

    wr_ptr_next = wr_ptr_reg;
    if (rsp_keep) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end

    tag_wr_ptr_next = tag_wr_ptr_reg;
    if (req_fire) begin
      tag_wr_ptr_next = tag_wr_ptr_reg + PTR_ONE;
    end

    tag_rd_ptr_next = tag_rd_ptr_reg;
    if (rsp_take) begin
      tag_rd_ptr_next = tag_rd_ptr_reg + PTR_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      fetch_pc_reg    <= RESET_PC;
      count_reg       <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      tag_rd_ptr_reg  <= '0;
      tag_wr_ptr_reg  <= '0;
      req_en_reg      <= 1'b0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
      tag_rd_ptr_reg  <= tag_rd_ptr_next;
      tag_wr_ptr_reg  <= tag_wr_ptr_next;
      req_en_reg      <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO entries and request PC tags. These are reset so that the head
  // outputs read zero while reset is asserted.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_fifo
      logic [31:0] pc_reg;
      logic [31:0] instr_reg;

      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          pc_reg    <= '0;
          instr_reg <= '0;
        end else if (rsp_keep && (wr_ptr_reg == AW'(gi))) begin
          pc_reg    <= tag_head;
          instr_reg <= mem_rsp_data_i;
        end
      end

      assign fifo_pc_w[gi]    = pc_reg;
      assign fifo_instr_w[gi] = instr_reg;
    end

    for (gi = 0; gi < DEPTH; gi++) begin : g_tag
      logic [31:0] tag_reg;

      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          tag_reg <= '0;
        end else if (req_fire && (tag_wr_ptr_reg == AW'(gi))) begin
          tag_reg <= fetch_pc_reg;
        end
      end

      assign tag_pc_w[gi] = tag_reg;
    end
  endgenerate

endmodule

// File: tb/tb_ifetch_prefetch.sv
// ----------------------------------------------------------------------------
// tb_ifetch_prefetch
//
// Self-checking bench for ifetch_prefetch. The reference model keeps the
// expected contents of the FIFO as a queue of {pc, data} entries.
// Each request is tagged with the fetch "epoch" it was issued in, and a
// redirect starts a new epoch. Responses for an older epoch, or responses
// that arrive in the redirect cycle, never become visible.
// The memory model returns word(addr) in order after a random latency.
// ----------------------------------------------------------------------------
module tb_ifetch_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0001_0000;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        mem_req_valid_o;
  logic [31:0] mem_req_addr_o;
  logic        mem_req_ready_i = 1'b0;
  logic        mem_rsp_valid_i = 1'b0;
  logic [31:0] mem_rsp_data_i = 32'h0;

  ifetch_prefetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i           (clk_i),
    .reset_ni        (reset_ni),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_ready_i   (instr_ready_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  req_t        pend[$];     // accepted requests still awaiting a response
  ent_t        mq[$];       // expected FIFO contents, head first
  logic [31:0] acc_log[$];  // addresses of accepted requests
  logic [31:0] del_log[$];  // PCs handed to IF

  int          cyc;
  int          epoch;
  logic [31:0] exp_fetch;
  int          first_acc_cyc;
  int          first_val_cyc;
  int          n_checks;
  int          n_pass;

  logic        drv_req_ready;
  logic        drv_instr_ready;
  logic        drv_redirect;
  logic [31:0] drv_redirect_pc;
  int          lat_min;
  int          lat_max;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  // One clock cycle, starting and ending at a falling edge.
  task automatic step();
    req_t p;
    ent_t e;
    logic rsp_now;
    logic acc_now;
    logic pop_now;
    rsp_now         = (pend.size() > 0) && (pend[0].due <= cyc);
    mem_rsp_valid_i = rsp_now;
    mem_rsp_data_i  = rsp_now ? mem_word(pend[0].addr) : $urandom;
    mem_req_ready_i = drv_req_ready;
    instr_ready_i   = drv_instr_ready;
    redirect_i      = drv_redirect;
    redirect_pc_i   = drv_redirect_pc;
    #1;
    n_checks++;
    if (instr_valid_o !== (mq.size() != 0))
      $display("FAIL cyc%0d instr_valid: got %b expected %b", cyc, instr_valid_o, mq.size() != 0);
    else n_pass++;
    if (mq.size() != 0) begin
      n_checks++;
      if (instr_pc_o !== mq[0].pc)
        $display("FAIL cyc%0d instr_pc: got %h expected %h", cyc, instr_pc_o, mq[0].pc);
      else n_pass++;
      n_checks++;
      if (instr_o !== mq[0].data)
        $display("FAIL cyc%0d instr: got %h expected %h", cyc, instr_o, mq[0].data);
      else n_pass++;
    end
    n_checks++;
    if (mem_req_valid_o !== ((mq.size() + pend.size()) < DEPTH))
      $display("FAIL cyc%0d mem_req_valid: got %b expected %b", cyc, mem_req_valid_o,
               (mq.size() + pend.size()) < DEPTH);
    else n_pass++;
    n_checks++;
    if (mem_req_addr_o !== exp_fetch)
      $display("FAIL cyc%0d mem_req_addr: got %h expected %h", cyc, mem_req_addr_o, exp_fetch);
    else n_pass++;

    acc_now = mem_req_valid_o & drv_req_ready;
    pop_now = instr_valid_o & drv_instr_ready;
    if (acc_now && first_acc_cyc < 0) first_acc_cyc = cyc;
    if (instr_valid_o && first_val_cyc < 0) first_val_cyc = cyc;
    if (pop_now) begin
      del_log.push_back(instr_pc_o);
      if (mq.size() > 0) void'(mq.pop_front());
    end
    if (rsp_now) begin
      p = pend.pop_front();
      if (p.epoch == epoch && !drv_redirect) begin
        e.pc   = p.addr;
        e.data = mem_word(p.addr);
        mq.push_back(e);
      end
    end
    if (acc_now) begin
      p.addr  = mem_req_addr_o;
      p.due   = cyc + int'($urandom_range(lat_max, lat_min));
      p.epoch = epoch;
      pend.push_back(p);
      acc_log.push_back(mem_req_addr_o);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (drv_redirect) begin
      mq.delete();
      epoch++;
      exp_fetch = {drv_redirect_pc[31:2], 2'b00};
    end
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
  endtask

  // Called at a falling edge while reset is low: clear the model and release.
  task automatic release_reset();
    pend.delete();
    mq.delete();
    acc_log.delete();
    del_log.delete();
    epoch++;
    exp_fetch       = RESET_PC;
    first_acc_cyc   = -1;
    first_val_cyc   = -1;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    instr_ready_i   = 1'b0;
    redirect_i      = 1'b0;
    drv_redirect    = 1'b0;
    reset_ni        = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic apply_reset();
    reset_ni        = 1'b0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    instr_ready_i   = 1'b0;
    redirect_i      = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    release_reset();
  endtask

  task automatic set_bus(input logic rr, input logic ir, input int lmin, input int lmax);
    drv_req_ready   = rr;
    drv_instr_ready = ir;
    lat_min         = lmin;
    lat_max         = lmax;
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (instr_valid_o !== 1'b0 || instr_o !== 32'h0 || instr_pc_o !== 32'h0 || mem_req_valid_o !== 1'b0)
      $display("FAIL reset_outputs: got valid=%b instr=%h pc=%h req=%b expected all zero",
               instr_valid_o, instr_o, instr_pc_o, mem_req_valid_o);
    else n_pass++;
    n_checks++;
    if (mem_req_addr_o !== RESET_PC)
      $display("FAIL reset_fetch_pc: got %h expected %h", mem_req_addr_o, RESET_PC);
    else n_pass++;
    @(negedge clk_i);
    release_reset();
    n_checks++;
    if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== RESET_PC || instr_valid_o !== 1'b0)
      $display("FAIL reset_first_req: got req=%b addr=%h valid=%b expected 1 %h 0",
               mem_req_valid_o, mem_req_addr_o, instr_valid_o, RESET_PC);
    else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_stream();
    apply_reset();
    set_bus(1'b1, 1'b1, 1, 1);
    for (int i = 0; i < 30; i++) step();
    n_checks++;
    if (first_val_cyc - first_acc_cyc !== 2)
      $display("FAIL stream_latency: got %0d expected 2", first_val_cyc - first_acc_cyc);
    else n_pass++;
    n_checks++;
    if (del_log.size() !== 28)
      $display("FAIL stream_throughput: got %0d deliveries expected 28", del_log.size());
    else n_pass++;
    n_checks++;
    if (del_log.size() == 0 || del_log[0] !== RESET_PC)
      $display("FAIL stream_first_pc: got %h expected %h",
               (del_log.size() == 0) ? 32'hx : del_log[0], RESET_PC);
    else n_pass++;
    $display("test_stream done: %0d delivered", del_log.size());
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_bus(1'b1, 1'b0, 1, 1);
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if (acc_log.size() !== DEPTH || mem_req_valid_o !== 1'b0)
      $display("FAIL bp_credit: got %0d accepted req=%b expected %0d 0",
               acc_log.size(), mem_req_valid_o, DEPTH);
    else n_pass++;
    for (int i = 0; i < acc_log.size() && i < DEPTH; i++) begin
      n_checks++;
      if (acc_log[i] !== RESET_PC + 32'(4 * i))
        $display("FAIL bp_addr%0d: got %h expected %h", i, acc_log[i], RESET_PC + 32'(4 * i));
      else n_pass++;
    end
    drv_instr_ready = 1'b1;
    step();
    drv_instr_ready = 1'b0;
    for (int i = 0; i < 6; i++) step();
    n_checks++;
    if (acc_log.size() !== DEPTH + 1 || acc_log[acc_log.size() - 1] !== 32'h0001_0010)
      $display("FAIL bp_refill: got %0d accepted last=%h expected 5 00010010",
               acc_log.size(), acc_log[acc_log.size() - 1]);
    else n_pass++;
    $display("test_backpressure done");
  endtask

  task automatic test_redirect_inflight();
    int idx;
    int stale;
    apply_reset();
    set_bus(1'b1, 1'b1, 5, 5);
    for (int i = 0; i < 3; i++) step();
    drv_redirect    = 1'b1;
    drv_redirect_pc = 32'h0002_0000;
    step();
    drv_redirect = 1'b0;
    idx = del_log.size();
    for (int i = 0; i < 30; i++) step();
    n_checks++;
    if (del_log.size() < idx + 2 || del_log[idx] !== 32'h0002_0000 || del_log[idx + 1] !== 32'h0002_0004)
      $display("FAIL inflight_order: got %0d deliveries first=%h expected 00020000 then 00020004",
               del_log.size() - idx, (del_log.size() > idx) ? del_log[idx] : 32'hx);
    else n_pass++;
    stale = 0;
    for (int i = idx; i < del_log.size(); i++)
      if (del_log[i] < 32'h0002_0000 || del_log[i] > 32'h0002_0100) stale++;
    n_checks++;
    if (stale !== 0) $display("FAIL inflight_stale: got %0d stale PCs expected 0", stale);
    else n_pass++;
    $display("test_redirect_inflight done");
  endtask

  task automatic test_redirect_collide();
    int idx;
    apply_reset();
    set_bus(1'b1, 1'b1, 1, 1);
    for (int i = 0; i < 6; i++) step();
    n_checks++;
    if (!(pend.size() > 0 && pend[0].due <= cyc) || instr_valid_o !== 1'b1)
      $display("FAIL collide_setup: got valid=%b rsp_pending=%0d expected 1 1", instr_valid_o, pend.size());
    else n_pass++;
    drv_redirect    = 1'b1;
    drv_redirect_pc = 32'h0002_0003;
    step();
    drv_redirect = 1'b0;
    idx = del_log.size();
    n_checks++;
    if (mem_req_addr_o !== 32'h0002_0000 || instr_valid_o !== 1'b0)
      $display("FAIL collide_restart: got addr=%h valid=%b expected 00020000 0", mem_req_addr_o, instr_valid_o);
    else n_pass++;
    for (int i = 0; i < 8; i++) step();
    n_checks++;
    if (del_log.size() <= idx || del_log[idx] !== 32'h0002_0000)
      $display("FAIL collide_first_pc: got %h expected 00020000",
               (del_log.size() > idx) ? del_log[idx] : 32'hx);
    else n_pass++;
    $display("test_redirect_collide done");
  endtask

  task automatic test_async_reset();
    int guard;
    apply_reset();
    set_bus(1'b1, 1'b0, 1, 1);
    step();
    step();
    drv_req_ready = 1'b0;
    guard = 0;
    while (mq.size() < 2 && guard < 10) begin
      step();
      guard++;
    end
    n_checks++;
    if (mq.size() !== 2 || instr_pc_o !== RESET_PC)
      $display("FAIL areset_setup: got %0d entries head=%h expected 2 %h", mq.size(), instr_pc_o, RESET_PC);
    else n_pass++;
    #2;
    reset_ni = 1'b0;
    #1;
    n_checks++;
    if (instr_valid_o !== 1'b0 || instr_o !== 32'h0 || instr_pc_o !== 32'h0 || mem_req_valid_o !== 1'b0)
      $display("FAIL areset_outputs: got valid=%b instr=%h pc=%h req=%b expected all zero",
               instr_valid_o, instr_o, instr_pc_o, mem_req_valid_o);
    else n_pass++;
    @(negedge clk_i);
    release_reset();
    n_checks++;
    if (mem_req_addr_o !== RESET_PC || mem_req_valid_o !== 1'b1 || instr_valid_o !== 1'b0)
      $display("FAIL areset_restart: got addr=%h req=%b valid=%b expected %h 1 0",
               mem_req_addr_o, mem_req_valid_o, instr_valid_o, RESET_PC);
    else n_pass++;
    $display("test_async_reset done");
  endtask

  task automatic test_wrap();
    int aidx;
    int didx;
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'hFFFF_FFF8;
    exp_seq[1] = 32'hFFFF_FFFC;
    exp_seq[2] = 32'h0000_0000;
    apply_reset();
    set_bus(1'b1, 1'b1, 1, 3);
    for (int i = 0; i < 3; i++) step();
    drv_redirect    = 1'b1;
    drv_redirect_pc = 32'hFFFF_FFF8;
    step();
    drv_redirect = 1'b0;
    aidx = acc_log.size();
    didx = del_log.size();
    for (int i = 0; i < 16; i++) step();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (acc_log.size() <= aidx + i || acc_log[aidx + i] !== exp_seq[i])
        $display("FAIL wrap_req%0d: got %h expected %h", i,
                 (acc_log.size() > aidx + i) ? acc_log[aidx + i] : 32'hx, exp_seq[i]);
      else n_pass++;
      n_checks++;
      if (del_log.size() <= didx + i || del_log[didx + i] !== exp_seq[i])
        $display("FAIL wrap_pc%0d: got %h expected %h", i,
                 (del_log.size() > didx + i) ? del_log[didx + i] : 32'hx, exp_seq[i]);
      else n_pass++;
    end
    $display("test_wrap done");
  endtask

  task automatic test_random();
    apply_reset();
    lat_min = 1;
    lat_max = 6;
    for (int i = 0; i < 2000; i++) begin
      drv_req_ready   = ($urandom_range(3, 0) != 0);
      drv_instr_ready = ($urandom_range(2, 0) != 0);
      drv_redirect    = ($urandom_range(39, 0) == 0);
      drv_redirect_pc = $urandom;
      step();
    end
    drv_redirect = 1'b0;
    set_bus(1'b1, 1'b1, 1, 1);
    for (int i = 0; i < 20; i++) step();
    n_checks++;
    if (instr_valid_o !== 1'b1 || mem_req_valid_o !== 1'b1)
      $display("FAIL random_recover: got valid=%b req=%b expected 1 1", instr_valid_o, mem_req_valid_o);
    else n_pass++;
    $display("test_random done: %0d delivered", del_log.size());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks        = 0;
    n_pass          = 0;
    cyc             = 0;
    epoch           = 0;
    exp_fetch       = RESET_PC;
    first_acc_cyc   = -1;
    first_val_cyc   = -1;
    drv_req_ready   = 1'b0;
    drv_instr_ready = 1'b0;
    drv_redirect    = 1'b0;
    drv_redirect_pc = 32'h0;
    lat_min         = 1;
    lat_max         = 1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collide();
    test_async_reset();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
